lbdr_input_fifo: RTL and testbench

- Per-input-port flit buffer feeding the LBDR route-compute stage of the router.
- Stores incoming flits in a circular FIFO and presents the head flit first-word-fall-through.
- Drives the LBDR stage's `empty`, `flit_id` and `dst_addr` inputs directly.
- Tracks packet framing on the read side and holds the current packet's destination from header to tail.

---
 rtl/lbdr_input_fifo.sv | 142 ++++++++++++++
 tb/tb_lbdr_input_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_input_fifo.sv
// rtl/lbdr_input_fifo.sv - FWFT input flit FIFO with read-side packet framing for LBDR route compute
// Optional protocol-error flag enabled by defining LBDR_FIFO_PROTO_CHECK_EN.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module lbdr_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_W:0]        count,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  pkt_active
`ifdef LBDR_FIFO_PROTO_CHECK_EN
    ,
    output logic                  proto_err
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;
    state_t                state_q;
    state_t                state_d;
    logic [3:0]            dst_q;
    logic [3:0]            dst_d;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    // A full FIFO can still take a write when the head is popped in the same cycle.
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_ok   = rd_en && !empty;

    assign rd_data    = mem[rd_ptr];
    assign flit_id    = rd_data[DATA_WIDTH-1 -: 3];
    assign dst_addr   = (flit_id == `HEADER) ? rd_data[3:0] : dst_q;
    assign pkt_active = (state_q == ACTIVE);

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state_q <= IDLE;
            dst_q   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + (PTR_W+1)'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - (PTR_W+1)'(1);
            end
            state_q <= state_d;
            dst_q   <= dst_d;
        end
    end

`ifdef LBDR_FIFO_PROTO_CHECK_EN
    logic pop_err;
`endif

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
`ifdef LBDR_FIFO_PROTO_CHECK_EN
        pop_err = 1'b0;
`endif
        if (rd_ok) begin
            case (state_q)
                IDLE: begin
                    if (flit_id == `HEADER) begin
                        state_d = ACTIVE;
                        dst_d   = rd_data[3:0];
                    end
`ifdef LBDR_FIFO_PROTO_CHECK_EN
                    else if (flit_id == `PAYLOAD || flit_id == `TAIL) begin
                        pop_err = 1'b1;
                    end
`endif
                end
                ACTIVE: begin
                    if (flit_id == `TAIL) begin
                        state_d = IDLE;
                    end else if (flit_id == `HEADER) begin
                        dst_d   = rd_data[3:0];
`ifdef LBDR_FIFO_PROTO_CHECK_EN
                        pop_err = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef LBDR_FIFO_PROTO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (pop_err || (wr_en && full && !rd_en) || (rd_en && empty)) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lbdr_input_fifo.sv
// tb/tb_lbdr_input_fifo.sv - queue-model bench for lbdr_input_fifo (directed plus random traffic)
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module tb_lbdr_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [2:0]    count;
    logic [2:0]    flit_id;
    logic [3:0]    dst_addr;
    logic          pkt_active;
`ifdef LBDR_FIFO_PROTO_CHECK_EN
    logic          proto_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a flit queue plus packet-framing state.
    logic [DW-1:0] q[$];
    bit            m_act;
    logic [3:0]    m_dst;
    bit            m_perr;

    lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .flit_id    (flit_id),
        .dst_addr   (dst_addr),
        .pkt_active (pkt_active)
`ifdef LBDR_FIFO_PROTO_CHECK_EN
        ,
        .proto_err  (proto_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [3:0] dst);
        logic [24:0] mid;
        mid = 25'($urandom);
        return {id, mid, dst};
    endfunction

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("pkt_active", 32'(pkt_active), 32'(m_act));
        if (q.size() != 0) begin
            chk("rd_data", rd_data, q[0]);
            chk("flit_id", 32'(flit_id), 32'(q[0][DW-1 -: 3]));
            chk("dst_addr", 32'(dst_addr),
                32'((q[0][DW-1 -: 3] == `HEADER) ? q[0][3:0] : m_dst));
        end
`ifdef LBDR_FIFO_PROTO_CHECK_EN
        chk("proto_err", 32'(proto_err), 32'(m_perr));
`endif
    endtask

    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
        bit            wacc;
        bit            racc;
        logic [DW-1:0] f;
        logic [2:0]    id;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        wacc = we && (q.size() < DEPTH || re);
        racc = re && (q.size() > 0);
        if (we && q.size() == DEPTH && !re) m_perr = 1;
        if (re && q.size() == 0) m_perr = 1;
        @(posedge clk);
        if (racc) begin
            f  = q.pop_front();
            id = f[DW-1 -: 3];
            if (!m_act) begin
                if (id == `HEADER) begin
                    m_act = 1;
                    m_dst = f[3:0];
                end else if (id == `PAYLOAD || id == `TAIL) begin
                    m_perr = 1;
                end
            end else begin
                if (id == `TAIL) begin
                    m_act = 0;
                end else if (id == `HEADER) begin
                    m_dst  = f[3:0];
                    m_perr = 1;
                end
            end
        end
        if (wacc) q.push_back(wd);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all();
    endtask

    task automatic do_reset(input logic we, input logic re);
        rst     = 1'b1;
        wr_en   = we;
        rd_en   = re;
        wr_data = mk(`HEADER, 4'h5);
        @(posedge clk);
        q.delete();
        m_act  = 0;
        m_dst  = '0;
        m_perr = 0;
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all();
    endtask

    initial begin
        logic [2:0] ids [4];
        ids[0] = `HEADER;
        ids[1] = `PAYLOAD;
        ids[2] = `TAIL;
        ids[3] = 3'b000;

        // Reset then idle.
        do_reset(1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0);

        // One three-flit packet, popped one per cycle.
        cycle(1'b1, mk(`HEADER, 4'hA), 1'b0);
        cycle(1'b1, mk(`PAYLOAD, 4'h3), 1'b0);
        cycle(1'b1, mk(`TAIL, 4'h7), 1'b0);
        repeat (3) begin
            chk("dst_hold", 32'(dst_addr), 32'h0000_000A);
            cycle(1'b0, '0, 1'b1);
        end

        // Overflow: five writes into a four-deep FIFO, then drain.
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(ids[i % 3], 4'(i)), 1'b0);
        // Write and read together while full.
        cycle(1'b1, mk(`TAIL, 4'hE), 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b1);

        // Write and read together while empty, then pointer wrap.
        cycle(1'b1, mk(`HEADER, 4'h6), 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(ids[i % 3], 4'(i)), 1'b1);
        cycle(1'b0, '0, 1'b1);

        // Reset mid-packet with requests pending.
        cycle(1'b1, mk(`HEADER, 4'hC), 1'b0);
        cycle(1'b1, mk(`PAYLOAD, 4'h1), 1'b1);
        do_reset(1'b1, 1'b1);
        // Stray payload before any header.
        cycle(1'b1, mk(`PAYLOAD, 4'h2), 1'b0);
        cycle(1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset(1'($urandom), 1'($urandom));
            end else begin
                cycle(1'($urandom_range(0, 99) < 55), mk(ids[$urandom_range(0, 3)], 4'($urandom)),
                      1'($urandom_range(0, 99) < 50));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
